// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the unified memory port.
// The arbiter takes the slave view; whatever drives the requesters and models
// the memory takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_done_o;
    logic              if_stall_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_done_o;
    logic              dm_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  mem_ack_i, mem_rdata_i,
        output if_rdata_o, if_done_o, if_stall_o,
        output dm_rdata_o, dm_done_o, dm_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output mem_ack_i, mem_rdata_i,
        input  if_rdata_o, if_done_o, if_stall_o,
        input  dm_rdata_o, dm_done_o, dm_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter for the CPU's single memory port: instruction fetch vs data access.
// Data access has priority, but after MAX_DM_RUN consecutive data grants with a
// fetch waiting, the fetch is served. A watchdog aborts WAIT after TIMEOUT
// cycles without ack and reports it on err_o alongside the done pulse.
//
// state  | meaning
// IDLE   | no transaction; pick a winner when any request is present
// WAIT   | mem_req_o held with latched address/data until ack or watchdog
// RESP   | owner's done pulse (and err_o on abort); requests ignored
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_DM_RUN = 4,
    parameter int TIMEOUT    = 255
) (
    input logic              clk_i,
    input logic              rst_i,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int RUN_W = $clog2(MAX_DM_RUN + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    logic [1:0]        state;
    logic [RUN_W-1:0]  run_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              owner_dm;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              if_done;
    logic              dm_done;
    logic              err;

    logic run_full;
    logic grant_dm;
    logic wd_expired;

    assign run_full   = (run_cnt == RUN_W'(MAX_DM_RUN));
    assign grant_dm   = bus.dm_req_i & ~(bus.if_req_i & run_full);
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // Arbitration, memory handshake, watchdog and response registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            run_cnt   <= '0;
            wd_cnt    <= '0;
            owner_dm  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.if_req_i || bus.dm_req_i) begin
                        owner_dm <= grant_dm;
                        mem_req  <= 1'b1;
                        wd_cnt   <= '0;
                        if (grant_dm) begin
                            mem_we    <= bus.dm_we_i;
                            mem_addr  <= bus.dm_addr_i;
                            mem_wdata <= bus.dm_wdata_i;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= bus.if_addr_i;
                            mem_wdata <= '0;
                        end
                        // Count only data grants that made a fetch wait.
                        if (grant_dm && bus.if_req_i) begin
                            if (!run_full) run_cnt <= run_cnt + 1'b1;
                        end else begin
                            run_cnt <= '0;
                        end
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_ack_i || wd_expired) begin
                        mem_req <= 1'b0;
                        if (owner_dm) begin
                            dm_done  <= 1'b1;
                            dm_rdata <= (bus.mem_ack_i && !mem_we) ? bus.mem_rdata_i : '0;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= bus.mem_ack_i ? bus.mem_rdata_i : '0;
                        end
                        err   <= ~bus.mem_ack_i;
                        state <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.dm_rdata_o  = dm_rdata;
    assign bus.if_done_o   = if_done;
    assign bus.dm_done_o   = dm_done;
    assign bus.err_o       = err;

    // Stalls drop in the done cycle so the pipeline advances on the next edge.
    assign bus.if_stall_o = bus.if_req_i & ~if_done;
    assign bus.dm_stall_o = bus.dm_req_i & ~dm_done;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port of the pipelined CPU between two requesters: instruction fetch (IF stage) and data access (MEM stage, loads/stores). It latches one request at a time, drives a multi-cycle req/ack memory handshake, returns read data with a one-cycle done pulse, and generates per-requester stall signals that feed the PC/IFID write-enables and the pipeline-register stalls. Data access has priority, bounded by an anti-starvation counter; a watchdog aborts memory transactions that never complete.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_RUN, 4, max consecutive data grants while IF is waiting (≥1)
- TIMEOUT, 255, WAIT-state cycles without ack before abort (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_done_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, valid while if_done_o=1
- if_done_o  out  1  one-cycle completion pulse for fetch
- if_stall_o  out  1  if_req_i & ~if_done_o (combinational)
- dm_req_i  in  1  data request, held until dm_done_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, valid while dm_done_o=1
- dm_done_o  out  1  one-cycle completion pulse for data
- dm_stall_o  out  1  dm_req_i & ~dm_done_o (combinational)
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion; read data valid same cycle
- mem_rdata_i  in  DATA_W  memory read data
- err_o  out  1  one-cycle pulse, coincident with done, on timeout abort

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if any req sampled high, pick grant, register addr/we/wdata and grant owner, load watchdog to 0, go WAIT. No req: stay.
- Grant rule: dm wins unless if_req_i=1 and run counter == MAX_DM_RUN, then IF wins. Only one requester: it wins.
- Run counter: increments on a dm grant made while if_req_i=1; clears on any IF grant or on a dm grant with if_req_i=0; saturates at MAX_DM_RUN.
- WAIT: mem_req_o=1, mem_we_o/addr/wdata from registers, stable throughout. mem_ack_i=1: capture mem_rdata_i (0 for stores), go RESP. Else watchdog++; watchdog reaching TIMEOUT: capture 0, set abort flag, go RESP.
- RESP: owner's done_o=1, its rdata_o=captured value, err_o=abort flag; requests not sampled; go IDLE. Other done_o stays 0.
- Requester still asserting req in the cycle after its done is treated as a new request.
- rdata outputs hold last captured value between pulses.
- Reset (any time, including mid-WAIT): state IDLE; mem_req_o, mem_we_o, if_done_o, dm_done_o, err_o = 0; mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o = 0; run counter, watchdog, abort flag = 0. In-flight transaction abandoned, no done issued.

## Timing
- All outputs except stalls are registered.
- Req sampled in IDLE at edge N -> mem_req_o high from N+1. Ack sampled at edge N+1+k (k ≥ 0 wait cycles) -> done high for cycle after that edge, IDLE next.
- Minimum latency req->done: 2 cycles (ack in first WAIT cycle); throughput: one transaction per 3 cycles minimum.
- Timeout: done+err_o appear in RESP after TIMEOUT WAIT cycles without ack; mem_req_o drops same edge WAIT exits.
- Ack arriving in IDLE/RESP is ignored.
- Stalls are combinational, fall in the done cycle so PC/IFID/EXMEM advance on the following edge.

## Test plan
- Single fetch, if_addr_i=0x10, ack after 0 waits, mem_rdata_i=0xDEADBEEF -> mem_req_o cycle 1, if_done_o cycle 2 with if_rdata_o=0xDEADBEEF, if_stall_o 1 in cycles 0–1, 0 in cycle 2.
- Simultaneous if_req_i and dm_req_i (load 0x40), ack 2 waits -> dm granted first, dm_done_o at cycle 4, then IF granted at cycle 5 IDLE.
- dm_req_i held continuously with if_req_i high, MAX_DM_RUN=4, ack 0 waits -> exactly 4 dm dones, then 1 if_done_o, then dm resumes.
- Store dm_we_i=1, addr 0x80, wdata 0x12345678 -> mem_we_o=1, mem_wdata_o=0x12345678 stable through WAIT, dm_done_o with dm_rdata_o=0.
- No ack, TIMEOUT=8 -> mem_req_o high exactly 8 cycles, then dm_done_o=1 and err_o=1 same cycle, dm_rdata_o=0.
- rst_i low mid-WAIT (3rd wait cycle) -> all outputs 0 immediately (asynchronously); after release, held request re-granted from IDLE, no spurious done.
